// File: rtl/rv32i_types.sv
// Shared RV32I front-end types.
// Purpose: line-buffer entry layout, bridge FSM encoding and the line
// geometry constants used by imem_line_bridge and imem_line_fill.
// Ports: none (package).
package rv32i_types;

  localparam int LINE_OFFSET_BITS = 5;
  localparam int BEAT_BITS        = 64;
  localparam int LINE_BEATS       = 4;
  localparam int TAG_BITS         = 32 - LINE_OFFSET_BITS;

  typedef struct packed {
    logic                             valid;
    logic [TAG_BITS-1:0]              tag;
    logic [LINE_BEATS*BEAT_BITS-1:0]  data;
  } line_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } imem_bridge_state_t;

endpackage

// File: rtl/imem_line_fill.sv
// Line fill engine for imem_line_bridge.
// Purpose: owns the IDLE/REQ/FILL FSM, the beat counter and the burst
// memory handshake. Collects BEATS beats into one line and emits a
// one-cycle install pulse carrying the line tag and data.
// Ports:
//   clk, rst        clock, async active-high reset
//   miss_req        fetch request present with no hit this cycle
//   miss_line       32 B aligned line address of the missing fetch
//   bmem_*          burst memory request / beat return
//   fill_start      one-cycle pulse when a miss is accepted (IDLE only)
//   install         one-cycle pulse when the last beat is accepted
//   install_tag     tag of the installed line
//   install_data    full line including the last beat
//   state_dbg       current FSM state, for observation
//
// Handshake: bmem_read is high only in a REQ cycle where bmem_ready is
// high; that single cycle is the accepted request. Returning beats are
// qualified by bmem_rvalid and must carry bmem_raddr equal to the
// requested line address, anything else is dropped.
module imem_line_fill
  import rv32i_types::*;
#(
  parameter int BEATS = LINE_BEATS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_req,
  input  logic [31:0]                miss_line,
  output logic [31:0]                bmem_addr,
  output logic                       bmem_read,
  input  logic                       bmem_ready,
  input  logic [31:0]                bmem_raddr,
  input  logic [BEAT_BITS-1:0]       bmem_rdata,
  input  logic                       bmem_rvalid,
  output logic                       fill_start,
  output logic                       install,
  output logic [TAG_BITS-1:0]        install_tag,
  output logic [BEATS*BEAT_BITS-1:0] install_data,
  output logic [1:0]                 state_dbg
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  imem_bridge_state_t         state_q;
  logic [31:0]                miss_addr_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [BEATS*BEAT_BITS-1:0] buf_q;
  logic                       beat_ok;
  logic                       last_beat;

  assign beat_ok    = (state_q == FILL) && bmem_rvalid && (bmem_raddr == miss_addr_q);
  assign last_beat  = (cnt_q == CNT_W'(BEATS - 1));
  assign fill_start = (state_q == IDLE) && miss_req;
  assign bmem_read  = (state_q == REQ) && bmem_ready;
  assign bmem_addr  = (state_q == REQ) ? miss_addr_q : 32'd0;
  assign install    = beat_ok && last_beat;
  assign install_tag = miss_addr_q[31:LINE_OFFSET_BITS];
  assign state_dbg  = state_q;

  // The last beat is merged straight into the install data so the line
  // lands in the entry array on the same edge that accepts that beat.
  always_comb begin
    install_data = buf_q;
    install_data[cnt_q*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= 32'd0;
      cnt_q       <= '0;
      buf_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_req) begin
            miss_addr_q <= miss_line;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (bmem_ready) begin
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (beat_ok) begin
            buf_q[cnt_q*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_line_bridge.sv
// Instruction-line bridge between the fetch stage and burst memory.
// Purpose: fully-associative buffer of NUM_LINES 32 B instruction lines.
// Hits answer combinationally in the same cycle; misses are filled by
// imem_line_fill as BEATS x 64-bit beats.
// Ports:
//   clk, rst              clock, async active-high reset
//   imem_addr/imem_rmask  fetch request (any nonzero mask = valid)
//   imem_rdata/imem_resp  instruction word, valid when imem_resp = 1
//   bmem_addr/bmem_read   line read request, taken when bmem_ready = 1
//   bmem_raddr/rdata/rvalid  returning burst beats
// The line offset is fixed at 5 bits, so BEATS must stay at LINE_BEATS.
module imem_line_bridge
  import rv32i_types::*;
#(
  parameter int NUM_LINES = 2,
  parameter int BEATS     = LINE_BEATS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [31:0] bmem_raddr,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  line_entry_t                entry_q [NUM_LINES];
  logic [IDX_W-1:0]           rr_q;
  logic [IDX_W-1:0]           victim_q;
  logic [IDX_W-1:0]           victim_sel;
  logic [IDX_W-1:0]           hit_idx;
  logic                       req;
  logic                       hit;
  logic                       found_free;
  logic [TAG_BITS-1:0]        req_tag;
  logic [BEATS*BEAT_BITS-1:0] hit_line;
  logic                       fill_start;
  logic                       install;
  logic [TAG_BITS-1:0]        install_tag;
  logic [BEATS*BEAT_BITS-1:0] install_data;
  logic [1:0]                 unused_fill_state;
  logic                       unused_addr_bits;

  assign req              = |imem_rmask;
  assign req_tag          = imem_addr[31:LINE_OFFSET_BITS];
  assign unused_addr_bits = ^imem_addr[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (!hit && req && entry_q[i].valid && (entry_q[i].tag == req_tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    hit_line   = entry_q[hit_idx].data;
    imem_resp  = hit;
    imem_rdata = hit ? hit_line[imem_addr[4:2]*32 +: 32] : 32'd0;
  end

  // A free entry is reused before the round-robin pointer evicts anything.
  always_comb begin
    victim_sel = rr_q;
    found_free = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (!found_free && !entry_q[i].valid) begin
        victim_sel = IDX_W'(i);
        found_free = 1'b1;
      end
    end
  end

  imem_line_fill #(.BEATS(BEATS)) u_fill (
    .clk          (clk),
    .rst          (rst),
    .miss_req     (req && !hit),
    .miss_line    ({imem_addr[31:LINE_OFFSET_BITS], 5'b0}),
    .bmem_addr    (bmem_addr),
    .bmem_read    (bmem_read),
    .bmem_ready   (bmem_ready),
    .bmem_raddr   (bmem_raddr),
    .bmem_rdata   (bmem_rdata),
    .bmem_rvalid  (bmem_rvalid),
    .fill_start   (fill_start),
    .install      (install),
    .install_tag  (install_tag),
    .install_data (install_data),
    .state_dbg    (unused_fill_state)
  );

  // The victim is invalidated as soon as its miss starts so it can never
  // answer with stale data while the replacement is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) entry_q[i] <= '0;
      rr_q     <= '0;
      victim_q <= '0;
    end else begin
      if (fill_start) begin
        victim_q                <= victim_sel;
        entry_q[victim_sel].valid <= 1'b0;
      end
      if (install) begin
        entry_q[victim_q] <= {1'b1, install_tag, install_data};
        rr_q <= (rr_q == IDX_W'(NUM_LINES - 1)) ? '0 : rr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_line_bridge.sv
// Testbench for imem_line_bridge: directed fetch/fill sequences with a
// scoreboard of expected instruction words.
module tb_imem_line_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  int checks;
  int failures;
  int read_cnt;
  logic        saw_read;
  logic [31:0] saw_addr;
  logic [31:0] exp_q[$];

  imem_line_bridge #(.NUM_LINES(2), .BEATS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Memory image: word w of line L is L ^ 0xC0DE0000 ^ {w,2'b01}.
  function automatic logic [31:0] word_val(input logic [31:0] line, input logic [2:0] w);
    return line ^ 32'hC0DE_0000 ^ {27'd0, w, 2'b01};
  endfunction

  function automatic logic [63:0] beat_val(input logic [31:0] line, input logic [1:0] n);
    return {word_val(line, {n, 1'b1}), word_val(line, {n, 1'b0})};
  endfunction

  // One fetch cycle: drive the request, push the expected word when a
  // hit is expected, sample at the falling edge and score the response.
  task automatic fetch_cycle(input logic [31:0] a, input logic [3:0] m, input logic hit);
    logic [31:0] exp_w;
    imem_addr  = a;
    imem_rmask = m;
    if (hit) exp_q.push_back(word_val({a[31:5], 5'b0}, a[4:2]));
    @(negedge clk);
    saw_read = bmem_read;
    saw_addr = bmem_addr;
    if (bmem_read) read_cnt++;
    check_eq("imem_resp", 32'(imem_resp), 32'(hit));
    if (exp_q.size() != 0 && (imem_resp || hit)) begin
      exp_w = exp_q.pop_front();
      if (imem_resp) check_eq("imem_rdata", imem_rdata, exp_w);
    end
    if (!imem_resp) check_eq("rdata_zero", imem_rdata, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Miss on 'line' from IDLE; expect bmem_read on the first ready cycle.
  task automatic do_req(input logic [31:0] line);
    logic done;
    logic exp_read;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (i == 0 || i >= 4) bmem_ready = 1'b1;
      else bmem_ready = ($urandom_range(0, 2) == 0);
      exp_read = (i >= 1) && bmem_ready;
      fetch_cycle(line, 4'hF, 1'b0);
      check_eq("bmem_read", 32'(saw_read), 32'(exp_read));
      if (saw_read) begin
        check_eq("bmem_addr", saw_addr, line);
        done = 1'b1;
      end
    end
    check_eq("req_done", 32'(done), 32'd1);
    bmem_ready = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] line, input logic [1:0] n, input logic [31:0] raddr,
                           input logic [31:0] fa, input logic fhit);
    bmem_rvalid = 1'b1;
    bmem_raddr  = raddr;
    bmem_rdata  = beat_val(line, n);
    fetch_cycle(fa, 4'hF, fhit);
    check_eq("no_read_in_fill", 32'(saw_read), 32'd0);
    bmem_rvalid = 1'b0;
  endtask

  task automatic do_fill(input logic [31:0] line);
    do_req(line);
    for (int n = 0; n < 4; n++) send_beat(line, 2'(n), line, line, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0; read_cnt = 0;
    saw_read = 1'b0; saw_addr = 32'd0;
    rst = 1'b0;
    imem_addr = 32'h1000_0000; imem_rmask = 4'hF;
    bmem_ready = 1'b1; bmem_raddr = 32'd0; bmem_rdata = 64'd0; bmem_rvalid = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_eq("rst_resp", 32'(imem_resp), 32'd0);
    check_eq("rst_rdata", imem_rdata, 32'd0);
    check_eq("rst_bmem_read", 32'(bmem_read), 32'd0);
    check_eq("rst_bmem_addr", bmem_addr, 32'd0);
    check_eq("rst_state", 32'(dut.u_fill.state_dbg), 32'(rv32i_types::IDLE));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; bmem_ready = 1'b0;

    // first line, then zero-stall sweep of all eight words
    do_fill(32'h1000_0000);
    for (int k = 0; k < 8; k++) fetch_cycle(32'h1000_0000 + 32'(k * 4), 4'hF, 1'b1);
    check_eq("read_count_first", 32'(read_cnt), 32'd1);

    // round-robin eviction: C evicts A, B survives
    do_fill(32'h0000_0000);
    do_fill(32'h0000_0020);
    do_fill(32'h0000_0040);
    fetch_cycle(32'h0000_0024, 4'hF, 1'b1);
    fetch_cycle(32'h0000_0044, 4'hF, 1'b1);
    do_fill(32'h0000_0000);
    fetch_cycle(32'h0000_0008, 4'hF, 1'b1);

    // redirects during a fill of 0x100
    do_fill(32'h0000_0020);
    do_req(32'h0000_0100);
    send_beat(32'h0000_0100, 2'd0, 32'h0000_0100, 32'h0000_0020, 1'b1);
    send_beat(32'h0000_0100, 2'd1, 32'h0000_0100, 32'h0000_003C, 1'b1);
    send_beat(32'h0000_0100, 2'd2, 32'h0000_0100, 32'h0000_0300, 1'b0);
    send_beat(32'h0000_0100, 2'd3, 32'h0000_0100, 32'h0000_0300, 1'b0);
    do_fill(32'h0000_0300);
    fetch_cycle(32'h0000_0310, 4'hF, 1'b1);
    fetch_cycle(32'h0000_0104, 4'hF, 1'b1);
    fetch_cycle(32'h0000_011C, 4'hF, 1'b1);

    // foreign beat is dropped, then reset lands mid-fill
    do_req(32'h0000_0200);
    send_beat(32'h0000_0200, 2'd0, 32'h0000_0200, 32'h0000_0200, 1'b0);
    send_beat(32'h0000_0200, 2'd1, 32'h0000_0200, 32'h0000_0200, 1'b0);
    send_beat(32'h0000_0220, 2'd3, 32'h0000_0220, 32'h0000_0200, 1'b0);
    send_beat(32'h0000_0200, 2'd2, 32'h0000_0200, 32'h0000_0200, 1'b0);
    fetch_cycle(32'h0000_0200, 4'hF, 1'b0);
    check_eq("still_filling", 32'(dut.u_fill.state_dbg), 32'(rv32i_types::FILL));
    fetch_cycle(32'h0000_0304, 4'hF, 1'b1);

    imem_addr = 32'h0000_0304;
    rst = 1'b1;
    #2;
    check_eq("midrst_resp", 32'(imem_resp), 32'd0);
    check_eq("midrst_rdata", imem_rdata, 32'd0);
    check_eq("midrst_bmem_read", 32'(bmem_read), 32'd0);
    check_eq("midrst_bmem_addr", bmem_addr, 32'd0);
    check_eq("midrst_state", 32'(dut.u_fill.state_dbg), 32'(rv32i_types::IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // rmask = 0 never requests; the leftover beat is discarded in IDLE
    bmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bmem_rvalid = (k == 0);
      bmem_raddr  = 32'h0000_0200;
      bmem_rdata  = beat_val(32'h0000_0200, 2'd3);
      fetch_cycle(32'h0000_0304 + 32'($urandom_range(0, 3) * 4), 4'h0, 1'b0);
      check_eq("mask0_no_read", 32'(saw_read), 32'd0);
      check_eq("mask0_idle", 32'(dut.u_fill.state_dbg), 32'(rv32i_types::IDLE));
    end
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b0;

    // every line is gone after reset: 0x300 misses again
    read_cnt = 0;
    do_req(32'h0000_0300);
    check_eq("read_count_after_rst", 32'(read_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
